// File: rtl/reg_arb_pkg.sv
// ---------------------------------------------------------------------------
// reg_arb_pkg
//   Shared types for the register-bank arbiter: access FSM states and the
//   identity of the two requesters, plus a helper that returns the opposite
//   requester (used by the round-robin tie-break).
// ---------------------------------------------------------------------------
package reg_arb_pkg;

    // Access sequencer: accept a request, perform it, report completion.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Requester identity: A is the SPI wrapper side, B is local on-chip logic.
    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;

    function automatic req_id_t other_id(input req_id_t id);
        return (id == REQ_A) ? REQ_B : REQ_A;
    endfunction

endpackage : reg_arb_pkg

// File: rtl/rr_arbiter_2.sv
// ---------------------------------------------------------------------------
// rr_arbiter_2
//   Purely combinational two-way round-robin pick. A lone request always
//   wins; when both request, the requester that was NOT granted last wins.
//   The last-grant history flop is owned by the caller.
//
//   Ports
//     i_a_req       in   1          requester A wants the bank
//     i_b_req       in   1          requester B wants the bank
//     i_last_grant  in   req_id_t   requester granted most recently
//     o_grant       out  req_id_t   selected requester (meaningful when o_valid)
//     o_valid       out  1          at least one request is pending
// ---------------------------------------------------------------------------
module rr_arbiter_2
    import reg_arb_pkg::*;
(
    input  logic    i_a_req,
    input  logic    i_b_req,
    input  req_id_t i_last_grant,
    output req_id_t o_grant,
    output logic    o_valid
);

    // NOTE: every output of a combinational block gets a default before any
    // branch; a path that leaves a signal unassigned would infer a latch.
    always_comb begin
        o_grant = REQ_A;
        o_valid = i_a_req | i_b_req;
        if (i_a_req && i_b_req) begin
            o_grant = other_id(i_last_grant);
        end else if (i_b_req) begin
            o_grant = REQ_B;
        end
    end

endmodule : rr_arbiter_2

// File: rtl/reg_bank_arbiter.sv
// ---------------------------------------------------------------------------
// reg_bank_arbiter
//   Shares one register bank between two requesters. The bank holds
//   NUM_REGS read/write config registers (stored here) and NUM_REGS
//   read-only status registers (supplied from outside). Addresses below
//   NUM_REGS select config, the next NUM_REGS select status, anything above
//   is out of range.
//
//   Each access takes three cycles: IDLE (arbitrate and latch the winner's
//   request), ACCESS (perform the read/write), RESP (winner sees a one-cycle
//   ack). ena=0 freezes every flop; rstb=0 at a clock edge aborts whatever
//   is in flight and restores reset values.
//
//   Ports
//     clk          in   1                   clock
//     rstb         in   1                   synchronous reset, active low
//     ena          in   1                   0 = hold all state
//     a_req        in   1                   A request level, held until a_ack
//     a_we         in   1                   A 1=write 0=read
//     a_addr       in   ADDR_W              A register address
//     a_wdata      in   REG_WIDTH           A write data
//     a_ack        out  1                   A one-cycle completion pulse
//     a_err        out  1                   A error flag, valid with a_ack
//     a_rdata      out  REG_WIDTH           A read data, updated with a read's ack
//     b_*                                   same set for requester B
//     status_regs  in   NUM_REGS*REG_WIDTH  status bank, reg i at [i*REG_WIDTH +: REG_WIDTH]
//     config_regs  out  NUM_REGS*REG_WIDTH  config bank, same packing
// ---------------------------------------------------------------------------
module reg_bank_arbiter
    import reg_arb_pkg::*;
#(
    parameter int                   NUM_REGS  = 8,
    parameter int                   REG_WIDTH = 8,
    parameter int                   ADDR_W    = $clog2(2 * NUM_REGS),
    parameter logic [REG_WIDTH-1:0] CFG_RESET = '0
) (
    input  logic                          clk,
    input  logic                          rstb,
    input  logic                          ena,

    input  logic                          a_req,
    input  logic                          a_we,
    input  logic [ADDR_W-1:0]             a_addr,
    input  logic [REG_WIDTH-1:0]          a_wdata,
    output logic                          a_ack,
    output logic                          a_err,
    output logic [REG_WIDTH-1:0]          a_rdata,

    input  logic                          b_req,
    input  logic                          b_we,
    input  logic [ADDR_W-1:0]             b_addr,
    input  logic [REG_WIDTH-1:0]          b_wdata,
    output logic                          b_ack,
    output logic                          b_err,
    output logic [REG_WIDTH-1:0]          b_rdata,

    input  logic [NUM_REGS*REG_WIDTH-1:0] status_regs,
    output logic [NUM_REGS*REG_WIDTH-1:0] config_regs
);

    localparam int CFG_IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                r_state;
    state_t                w_state_next;

    req_id_t               r_last_grant;
    req_id_t               r_id;
    logic                  r_we;
    logic [ADDR_W-1:0]     r_addr;
    logic [REG_WIDTH-1:0]  r_wdata;

    logic [REG_WIDTH-1:0]  r_cfg [NUM_REGS];

    logic                  r_a_ack;
    logic                  r_a_err;
    logic [REG_WIDTH-1:0]  r_a_rdata;
    logic                  r_b_ack;
    logic                  r_b_err;
    logic [REG_WIDTH-1:0]  r_b_rdata;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    req_id_t               w_grant;
    logic                  w_grant_valid;
    logic                  w_latch;
    logic                  w_do_access;
    logic                  w_finish;

    logic [31:0]           w_addr_ext;
    logic [31:0]           w_st_idx_ext;
    logic                  w_is_cfg;
    logic                  w_is_status;
    logic [CFG_IDX_W-1:0]  w_cfg_idx;
    logic [REG_WIDTH-1:0]  w_cfg_word;
    logic [REG_WIDTH-1:0]  w_status_word;
    logic [REG_WIDTH-1:0]  w_rd_word;
    logic                  w_acc_err;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    rr_arbiter_2 u_rr_arbiter_2 (
        .i_a_req      (a_req),
        .i_b_req      (b_req),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_valid      (w_grant_valid)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    // NOTE: clocked state is always updated with non-blocking assignments so
    // every flop samples the values from before the edge, independent of
    // the order in which always blocks are evaluated.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            r_state <= IDLE;
        end else if (ena) begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_latch      = 1'b0;
        w_do_access  = 1'b0;
        w_finish     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_grant_valid) begin
                    w_latch      = 1'b1;
                    w_state_next = ACCESS;
                end
            end
            ACCESS: begin
                w_do_access  = 1'b1;
                w_state_next = RESP;
            end
            RESP: begin
                w_finish     = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Latched request of the current owner. Once granted, the access runs to
    // completion even if the requester drops its request line.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstb) begin
            r_last_grant <= REQ_B;  // makes A the winner of the first tie
            r_id         <= REQ_A;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
        end else if (ena && w_latch) begin
            r_last_grant <= w_grant;
            r_id         <= w_grant;
            if (w_grant == REQ_A) begin
                r_we    <= a_we;
                r_addr  <= a_addr;
                r_wdata <= a_wdata;
            end else begin
                r_we    <= b_we;
                r_addr  <= b_addr;
                r_wdata <= b_wdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Address decode and read mux
    // ------------------------------------------------------------------
    assign w_addr_ext   = 32'(r_addr);
    assign w_st_idx_ext = w_addr_ext - 32'(NUM_REGS);
    assign w_is_cfg     = (w_addr_ext < 32'(NUM_REGS));
    assign w_is_status  = !w_is_cfg && (w_addr_ext < 32'(2 * NUM_REGS));
    assign w_cfg_idx    = r_addr[CFG_IDX_W-1:0];
    assign w_cfg_word   = r_cfg[w_cfg_idx];

    always_comb begin
        w_status_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_st_idx_ext == 32'(i)) begin
                w_status_word = status_regs[i*REG_WIDTH +: REG_WIDTH];
            end
        end
    end

    // Out-of-range reads return zero; writes are only legal to config.
    assign w_rd_word = w_is_cfg    ? w_cfg_word    :
                       w_is_status ? w_status_word : '0;
    assign w_acc_err = r_we ? !w_is_cfg : !(w_is_cfg || w_is_status);

    // ------------------------------------------------------------------
    // Config storage
    // ------------------------------------------------------------------
    // NOTE: the config array is architectural state seen by the rest of the
    // chip, so every entry is reset explicitly rather than left as
    // uninitialised memory.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_cfg[i] <= CFG_RESET;
            end
        end else if (ena && w_do_access && r_we && w_is_cfg) begin
            r_cfg[w_cfg_idx] <= r_wdata;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_cfg_pack
        assign config_regs[g*REG_WIDTH +: REG_WIDTH] = r_cfg[g];
    end

    // ------------------------------------------------------------------
    // Per-port response flops. Ack/err are loaded at the end of ACCESS so
    // they are high during the RESP cycle only; read data changes together
    // with the ack of a read and is otherwise held.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstb) begin
            r_a_ack   <= 1'b0;
            r_a_err   <= 1'b0;
            r_a_rdata <= '0;
            r_b_ack   <= 1'b0;
            r_b_err   <= 1'b0;
            r_b_rdata <= '0;
        end else if (ena) begin
            if (w_do_access) begin
                r_a_ack <= (r_id == REQ_A);
                r_a_err <= (r_id == REQ_A) && w_acc_err;
                r_b_ack <= (r_id == REQ_B);
                r_b_err <= (r_id == REQ_B) && w_acc_err;
                if (!r_we) begin
                    if (r_id == REQ_A) begin
                        r_a_rdata <= w_rd_word;
                    end else begin
                        r_b_rdata <= w_rd_word;
                    end
                end
            end else if (w_finish) begin
                r_a_ack <= 1'b0;
                r_a_err <= 1'b0;
                r_b_ack <= 1'b0;
                r_b_err <= 1'b0;
            end
        end
    end

    assign a_ack   = r_a_ack;
    assign a_err   = r_a_err;
    assign a_rdata = r_a_rdata;
    assign b_ack   = r_b_ack;
    assign b_err   = r_b_err;
    assign b_rdata = r_b_rdata;

endmodule : reg_bank_arbiter

// File: tb/tb_reg_bank_arbiter.sv
// ---------------------------------------------------------------------------
// tb_reg_bank_arbiter
//   Directed scenarios followed by randomized request rounds, each checked
//   against a transaction-level model of the register bank: a plain array of
//   config values, the last granted requester, and the rule that a tie goes
//   to whoever was not granted last. Outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_reg_bank_arbiter;

    localparam int NR = 8;
    localparam int RW = 8;
    localparam int AW = 4;

    logic             clk = 1'b0;
    logic             rstb;
    logic             ena;
    logic             a_req, a_we, b_req, b_we;
    logic [AW-1:0]    a_addr, b_addr;
    logic [RW-1:0]    a_wdata, b_wdata, a_rdata, b_rdata;
    logic             a_ack, a_err, b_ack, b_err;
    logic [NR*RW-1:0] status_regs;
    logic [NR*RW-1:0] config_regs;

    always #5 clk = ~clk;

    reg_bank_arbiter #(
        .NUM_REGS  (NR),
        .REG_WIDTH (RW),
        .ADDR_W    (AW),
        .CFG_RESET ('0)
    ) dut (
        .clk         (clk),
        .rstb        (rstb),
        .ena         (ena),
        .a_req       (a_req),
        .a_we        (a_we),
        .a_addr      (a_addr),
        .a_wdata     (a_wdata),
        .a_ack       (a_ack),
        .a_err       (a_err),
        .a_rdata     (a_rdata),
        .b_req       (b_req),
        .b_we        (b_we),
        .b_addr      (b_addr),
        .b_wdata     (b_wdata),
        .b_ack       (b_ack),
        .b_err       (b_err),
        .b_rdata     (b_rdata),
        .status_regs (status_regs),
        .config_regs (config_regs)
    );

    int n_total = 0;
    int n_bad   = 0;

    // Reference model (port index 0 = A, 1 = B)
    logic [RW-1:0] m_cfg [NR];
    int            m_last;
    logic [RW-1:0] m_rdata [2];
    bit            req_we   [2];
    logic [AW-1:0] req_addr [2];
    logic [RW-1:0] req_wd   [2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [NR*RW-1:0] model_packed();
        logic [NR*RW-1:0] v;
        for (int i = 0; i < NR; i++) v[i*RW +: RW] = m_cfg[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_cfg[i] = '0;
        m_last     = 1;
        m_rdata[0] = '0;
        m_rdata[1] = '0;
    endtask

    // Apply one completed access of port p to the model.
    task automatic model_access(input int p, output bit e_err, output logic [RW-1:0] e_rd);
        int ad;
        ad    = int'(req_addr[p]);
        e_err = 1'b0;
        if (req_we[p]) begin
            if (ad < NR) m_cfg[ad] = req_wd[p];
            else         e_err = 1'b1;
        end else begin
            if (ad < NR)           m_rdata[p] = m_cfg[ad];
            else if (ad < 2 * NR)  m_rdata[p] = status_regs[(ad - NR)*RW +: RW];
            else begin
                m_rdata[p] = '0;
                e_err      = 1'b1;
            end
        end
        e_rd = m_rdata[p];
    endtask

    task automatic set_port(input int p, input bit r, input bit we,
                            input logic [AW-1:0] ad, input logic [RW-1:0] wd);
        if (p == 0) begin
            a_req = r; a_we = we; a_addr = ad; a_wdata = wd;
        end else begin
            b_req = r; b_we = we; b_addr = ad; b_wdata = wd;
        end
    endtask

    // Check one observed ack against the model's next expected completion.
    task automatic check_ack(input string tag, input int exp_p);
        int            p;
        bit            e_err;
        logic [RW-1:0] e_rd;
        check({tag, "_ack_onehot"}, 64'(a_ack && b_ack), 64'(0));
        p      = a_ack ? 0 : 1;
        check({tag, "_ack_port"}, 64'(p), 64'(exp_p));
        m_last = exp_p;
        model_access(exp_p, e_err, e_rd);
        check({tag, "_err"}, 64'(p == 0 ? a_err : b_err), 64'(e_err));
        if (!req_we[exp_p]) check({tag, "_rdata"}, 64'(p == 0 ? a_rdata : b_rdata), 64'(e_rd));
        check({tag, "_config"}, config_regs, model_packed());
        set_port(p, 1'b0, 1'b0, '0, '0);
    endtask

    // One round: raise the requested ports together, wait for every expected
    // ack (bounded), check order, latency and results.
    task automatic do_round(input string tag,
                            input bit ra, input bit wa, input logic [AW-1:0] aa, input logic [RW-1:0] da,
                            input bit rb, input bit wb, input logic [AW-1:0] ab, input logic [RW-1:0] db);
        int order [2];
        int n_exp;
        int done;
        int cyc;
        req_we[0] = wa; req_addr[0] = aa; req_wd[0] = da;
        req_we[1] = wb; req_addr[1] = ab; req_wd[1] = db;
        n_exp    = 0;
        order[0] = 0;
        order[1] = 1;
        if (ra && rb) begin
            order[0] = (m_last == 0) ? 1 : 0;
            order[1] = 1 - order[0];
            n_exp    = 2;
        end else if (ra) begin
            order[0] = 0; n_exp = 1;
        end else if (rb) begin
            order[0] = 1; n_exp = 1;
        end
        @(negedge clk);
        check({tag, "_idle_noack"}, 64'({a_ack, b_ack}), 64'(0));
        set_port(0, ra, wa, aa, da);
        set_port(1, rb, wb, ab, db);
        done = 0;
        cyc  = 0;
        while (done < n_exp && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (a_ack || b_ack) begin
                check({tag, "_latency"}, 64'(cyc), 64'(2 + 3 * done));
                check_ack(tag, order[done]);
                done++;
            end
        end
        if (done < n_exp) begin
            check({tag, "_timeout"}, 64'(done), 64'(n_exp));
            set_port(0, 1'b0, 1'b0, '0, '0);
            set_port(1, 1'b0, 1'b0, '0, '0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstb        = 1'b0;
        ena         = 1'b1;
        status_regs = '0;
        set_port(0, 1'b0, 1'b0, '0, '0);
        set_port(1, 1'b0, 1'b0, '0, '0);
        model_reset();

        // 1: reset
        repeat (2) @(negedge clk);
        check("rst_config", config_regs, 64'(0));
        check("rst_acks",   64'({a_ack, b_ack}), 64'(0));
        check("rst_rdata",  64'({a_rdata, b_rdata}), 64'(0));
        rstb = 1'b1;

        // 2: A write then read of config reg 3
        do_round("t2_wr", 1'b1, 1'b1, 4'd3, 8'h5C, 1'b0, 1'b0, 4'd0, 8'h00);
        check("t2_cfg3", 64'(config_regs[31:24]), 64'h5C);
        do_round("t2_rd", 1'b1, 1'b0, 4'd3, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
        check("t2_rdata", 64'(a_rdata), 64'h5C);

        // 4: B reads status reg 1, then tries to write it
        status_regs = 64'h0807_0605_0403_1001;
        do_round("t4_rd", 1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 4'd9, 8'h00);
        check("t4_rdata", 64'(b_rdata), 64'h10);
        do_round("t4_wr", 1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 4'd9, 8'hEE);
        check("t4_err", 64'(b_err), 64'(1));

        // 3: simultaneous writes to reg 0, then another tie
        do_round("t3_tie", 1'b1, 1'b1, 4'd0, 8'h11, 1'b1, 1'b1, 4'd0, 8'h22);
        check("t3_cfg0", 64'(config_regs[7:0]), 64'h22);
        do_round("t3_tie2", 1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 4'd3, 8'h00);

        // 5: freeze while in ACCESS
        @(negedge clk);
        req_we[0] = 1'b1; req_addr[0] = 4'd5; req_wd[0] = 8'h77;
        set_port(0, 1'b1, 1'b1, 4'd5, 8'h77);
        @(negedge clk);
        ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t5_frozen_ack", 64'({a_ack, b_ack}), 64'(0));
            check("t5_frozen_cfg", config_regs, model_packed());
        end
        ena = 1'b1;
        @(negedge clk);
        check("t5_ack_after_ena", 64'(a_ack), 64'(1));
        if (a_ack || b_ack) check_ack("t5", 0);
        else set_port(0, 1'b0, 1'b0, '0, '0);

        // 6: reset during ACCESS of a write
        @(negedge clk);
        set_port(0, 1'b1, 1'b1, 4'd2, 8'hAB);
        @(negedge clk);
        rstb = 1'b0;
        set_port(0, 1'b0, 1'b0, '0, '0);
        repeat (2) begin
            @(negedge clk);
            check("t6_rst_noack", 64'({a_ack, b_ack}), 64'(0));
        end
        rstb = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t6_noack", 64'({a_ack, b_ack}), 64'(0));
            check("t6_config", config_regs, 64'(0));
        end
        check("t6_rdata", 64'({a_rdata, b_rdata}), 64'(0));

        // Randomized rounds
        for (int r = 0; r < 150; r++) begin
            int sel;
            sel = int'($urandom_range(1, 3));
            if ($urandom_range(0, 3) == 0) status_regs = {$urandom, $urandom};
            do_round("rnd",
                     sel[0], 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom),
                     sel[1], 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_reg_bank_arbiter
